// File: rtl/input_debounce_if.sv
// input_debounce_if: groups the raw board inputs and the conditioned levels
// that feed the PDU debug unit. The master side drives raw pins and observes
// the clean outputs; the slave side is the debounce block itself.
interface input_debounce_if;
  logic       run_raw;
  logic       step_raw;
  logic       valid_raw;
  logic [4:0] in_raw;
  logic       run;
  logic       step;
  logic       valid;
  logic [4:0] in;
  logic [7:0] chg;

  modport master (
    output run_raw, step_raw, valid_raw, in_raw,
    input  run, step, valid, in, chg
  );

  modport slave (
    input  run_raw, step_raw, valid_raw, in_raw,
    output run, step, valid, in, chg
  );
endinterface

// File: rtl/input_debounce.sv
// input_debounce: two-flop synchronizer plus per-channel stable-time debounce
// for the eight raw board inputs {run, step, valid, in[4:0]}. A channel's
// stable value changes only after its synchronized input has differed from
// it for DB_CYCLES consecutive cycles; chg pulses for one cycle when the new
// value first appears.
//
// Optional feature macro: STEP_REPEAT_EN. When defined, holding the step
// button produces one-cycle low dips on the step output after REP_DELAY
// cycles and then every REP_PERIOD cycles, giving the PDU repeated rising
// edges. When undefined, step is the plain debounced level.
module input_debounce #(
  parameter int DB_CYCLES  = 1000000,
  parameter int CNT_W      = 20,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input_debounce_if.slave   bus
);

  // Channel index of the step button inside the {run, step, valid, in} vector.
  localparam int STEP_CH = 6;

  // Counter value on which a differing input is accepted as the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Elaboration-time parameter legality checks.
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("input_debounce: DB_CYCLES must be at least 2");
  end
  if ((64'd1 << CNT_W) < 64'(DB_CYCLES)) begin : g_bad_cnt_w
    $error("input_debounce: CNT_W too narrow for DB_CYCLES");
  end
  if ((REP_DELAY < 1) || (REP_PERIOD < 1)) begin : g_bad_rep
    $error("input_debounce: REP_DELAY and REP_PERIOD must be at least 1");
  end

  // Raw inputs packed in channel order {run, step, valid, in[4:0]}.
  logic [7:0]       raw_s;

  // Synchronizer stages; only s2 is seen by the debounce logic.
  logic [7:0]       s1_r;
  logic [7:0]       s2_r;

  // Debounced levels, change pulses and per-channel stable-time counters.
  logic [7:0]       stable_r;
  logic [7:0]       chg_r;
  logic [CNT_W-1:0] cnt_r      [8];

  // Next-state values from the debounce decision.
  logic [7:0]       stable_nxt_s;
  logic [7:0]       accept_s;
  logic [CNT_W-1:0] cnt_nxt_s  [8];

  // Step output after optional auto-repeat shaping.
  logic             step_out_s;

  assign raw_s = {bus.run_raw, bus.step_raw, bus.valid_raw, bus.in_raw};

  // Two-flop synchronizer for every raw input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 8'h00;
      s2_r <= 8'h00;
    end else begin
      s1_r <= raw_s;
      s2_r <= s1_r;
    end
  end

  // Per-channel debounce decision: restart on agreement, accept on the last
  // count, otherwise keep counting. The counter never passes CNT_LAST.
  always_comb begin
    stable_nxt_s = stable_r;
    accept_s     = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cnt_nxt_s[i] = {CNT_W{1'b0}};
      if (s2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_nxt_s[i] = s2_r[i];
        accept_s[i]     = 1'b1;
        cnt_nxt_s[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CNT_W'(1);
      end
    end
  end

  // Debounce state: stable levels, counters and the one-cycle change pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_r <= 8'h00;
      chg_r    <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      stable_r <= stable_nxt_s;
      chg_r    <= accept_s;
      for (int i = 0; i < 8; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

`ifdef STEP_REPEAT_EN
  // Auto-repeat for the step button: a hold counter runs while the stable
  // step level is 1. The first dip comes REP_DELAY cycles after the level
  // rises; after that the counter restarts and dips every REP_PERIOD cycles.
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_V  = REP_W'(REP_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD_V = REP_W'(REP_PERIOD);

  logic [REP_W-1:0] hold_r;
  logic [REP_W-1:0] hold_inc_s;
  logic [REP_W-1:0] hold_nxt_s;
  logic             rep_phase_r;
  logic             rep_phase_nxt_s;
  logic             dip_s;
  logic             step_r;

  // Hold-counter next state and the dip request for the coming cycle.
  always_comb begin
    hold_inc_s      = hold_r + REP_W'(1);
    hold_nxt_s      = {REP_W{1'b0}};
    rep_phase_nxt_s = 1'b0;
    dip_s           = 1'b0;
    if (!stable_r[STEP_CH]) begin
      hold_nxt_s      = {REP_W{1'b0}};
      rep_phase_nxt_s = 1'b0;
      dip_s           = 1'b0;
    end else if ((!rep_phase_r && (hold_inc_s == REP_DELAY_V)) ||
                 ( rep_phase_r && (hold_inc_s == REP_PERIOD_V))) begin
      hold_nxt_s      = {REP_W{1'b0}};
      rep_phase_nxt_s = 1'b1;
      dip_s           = 1'b1;
    end else begin
      hold_nxt_s      = hold_inc_s;
      rep_phase_nxt_s = rep_phase_r;
      dip_s           = 1'b0;
    end
  end

  // Hold counter, repeat phase and the registered, dip-shaped step output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r      <= {REP_W{1'b0}};
      rep_phase_r <= 1'b0;
      step_r      <= 1'b0;
    end else begin
      hold_r      <= hold_nxt_s;
      rep_phase_r <= rep_phase_nxt_s;
      step_r      <= stable_nxt_s[STEP_CH] & ~dip_s;
    end
  end

  assign step_out_s = step_r;
`else
  assign step_out_s = stable_r[STEP_CH];
`endif

  // Every output is taken straight from a flop.
  assign bus.run   = stable_r[7];
  assign bus.step  = step_out_s;
  assign bus.valid = stable_r[5];
  assign bus.in    = stable_r[4:0];
  assign bus.chg   = chg_r;

endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed-vector bench for input_debounce with
// DB_CYCLES=4, REP_DELAY=10, REP_PERIOD=5. Expected auto-repeat behaviour
// follows whether STEP_REPEAT_EN is defined for the build.
module tb_input_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  input_debounce_if dbif ();

  input_debounce #(
    .DB_CYCLES (4),
    .CNT_W     (3),
    .REP_DELAY (10),
    .REP_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dbif)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  logic [7:0] outs_s;
  assign outs_s = {dbif.run, dbif.step, dbif.valid, dbif.in};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raw(input logic [7:0] v);
    dbif.run_raw   = v[7];
    dbif.step_raw  = v[6];
    dbif.valid_raw = v[5];
    dbif.in_raw    = v[4:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_raw(8'(i * 37 + 5));
      tick();
      checks++;
      if (outs_s !== 8'h00 || dbif.chg !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d outs=%h chg=%h expected 00/00", i, outs_s, dbif.chg);
      end
    end
    set_raw(8'h00);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (outs_s !== 8'h00 || dbif.chg !== 8'h00) begin
        failures++;
        $display("FAIL reset_release cyc=%0d outs=%h chg=%h expected 00/00", i, outs_s, dbif.chg);
      end
    end
  endtask

  task automatic test_clean_edge();
    set_raw(8'h15);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (dbif.in !== 5'b00000 || dbif.chg !== 8'h00) begin
        failures++;
        $display("FAIL clean_early edge=%0d in=%b chg=%h expected 00000/00", k, dbif.in, dbif.chg);
      end
    end
    tick();
    checks++;
    if (dbif.in !== 5'b10101 || dbif.chg !== 8'h15) begin
      failures++;
      $display("FAIL clean_rise in=%b chg=%h expected 10101/15", dbif.in, dbif.chg);
    end
    tick();
    checks++;
    if (dbif.in !== 5'b10101 || dbif.chg !== 8'h00) begin
      failures++;
      $display("FAIL clean_after in=%b chg=%h expected 10101/00", dbif.in, dbif.chg);
    end
  endtask

  task automatic test_bounce();
    logic       lvl [4];
    int         wid [4];
    lvl = '{1'b1, 1'b0, 1'b1, 1'b0};
    wid = '{2, 1, 3, 2};
    for (int p = 0; p < 4; p++) begin
      set_raw({1'b0, lvl[p], 1'b0, 5'b10101});
      for (int w = 0; w < wid[p]; w++) begin
        tick();
        checks++;
        if (dbif.step !== 1'b0 || dbif.chg !== 8'h00) begin
          failures++;
          $display("FAIL bounce_glitch phase=%0d step=%b chg=%h expected 0/00", p, dbif.step, dbif.chg);
        end
      end
    end
    set_raw(8'h55);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (dbif.step !== 1'b0 || dbif.chg !== 8'h00) begin
        failures++;
        $display("FAIL bounce_settle edge=%0d step=%b chg=%h expected 0/00", k, dbif.step, dbif.chg);
      end
    end
    tick();
    checks++;
    if (dbif.step !== 1'b1 || dbif.chg !== 8'h40) begin
      failures++;
      $display("FAIL bounce_rise step=%b chg=%h expected 1/40", dbif.step, dbif.chg);
    end
    tick();
    checks++;
    if (dbif.step !== 1'b1 || dbif.chg !== 8'h00) begin
      failures++;
      $display("FAIL bounce_after step=%b chg=%h expected 1/00", dbif.step, dbif.chg);
    end
  endtask

  task automatic test_simultaneous();
    set_raw(8'hF5);
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (dbif.run !== 1'b0 || dbif.valid !== 1'b0 || dbif.chg !== 8'h00) begin
        failures++;
        $display("FAIL simul_early edge=%0d run=%b valid=%b chg=%h expected 0/0/00",
                 k, dbif.run, dbif.valid, dbif.chg);
      end
    end
    tick();
    checks++;
    if (dbif.run !== 1'b1 || dbif.valid !== 1'b1 || dbif.chg !== 8'hA0) begin
      failures++;
      $display("FAIL simul_rise run=%b valid=%b chg=%h expected 1/1/a0", dbif.run, dbif.valid, dbif.chg);
    end
    tick();
    checks++;
    if (dbif.run !== 1'b1 || dbif.valid !== 1'b1 || dbif.chg !== 8'h00) begin
      failures++;
      $display("FAIL simul_after run=%b valid=%b chg=%h expected 1/1/00", dbif.run, dbif.valid, dbif.chg);
    end
  endtask

  task automatic test_reset_mid_count();
    set_raw(8'hF7);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (dbif.in !== 5'b10101 || dbif.chg !== 8'h00) begin
        failures++;
        $display("FAIL midcnt_count edge=%0d in=%b chg=%h expected 10101/00", k, dbif.in, dbif.chg);
      end
    end
    rst = 1'b1;
    set_raw(8'h00);
    #1;
    checks++;
    if (outs_s !== 8'h00 || dbif.chg !== 8'h00) begin
      failures++;
      $display("FAIL midcnt_async outs=%h chg=%h expected 00/00", outs_s, dbif.chg);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (outs_s !== 8'h00 || dbif.chg !== 8'h00) begin
        failures++;
        $display("FAIL midcnt_after edge=%0d outs=%h chg=%h expected 00/00", k, outs_s, dbif.chg);
      end
    end
  endtask

  task automatic test_auto_repeat();
    logic       exp_step;
    logic [7:0] exp_chg;
    logic       dip;
    set_raw(8'h40);
    for (int k = 1; k <= 45; k++) begin
      if (k == 31) begin
        set_raw(8'h00);
      end
      tick();
`ifdef STEP_REPEAT_EN
      dip = (k >= 16) && (k < 36) && (((k - 16) % 5) == 0);
`else
      dip = 1'b0;
`endif
      exp_step = (k >= 6) && (k < 36) && !dip;
      exp_chg  = ((k == 6) || (k == 36)) ? 8'h40 : 8'h00;
      checks++;
      if (dbif.step !== exp_step || dbif.chg !== exp_chg) begin
        failures++;
        $display("FAIL repeat edge=%0d step=%b chg=%h expected %b/%h",
                 k, dbif.step, dbif.chg, exp_step, exp_chg);
      end
    end
  endtask

  initial begin
    set_raw(8'h00);
    test_reset();
    test_clean_edge();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_auto_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
